// File: rtl/ddls_input_pkg.sv
// Shared types and defaults for the DDLS input stage: FSM state encoding,
// board-rate default timings and a counter-width helper.
package ddls_input_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } in_state_t;

  // 20 ms debounce and 0.5 s auto-repeat at 50 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEFAULT_REPEAT_CYCLES   = 25_000_000;

  // Bits needed to count 0 .. n-1, never less than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddls_input_stage_debounce.sv
// debounce_filter: synchronises a raw active-low button and accepts a level
// change only after it has been stable for DEBOUNCE_CYCLES clock cycles.
module debounce_filter
  import ddls_input_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic deb_level
);

  localparam int unsigned      CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   level_reg;
  logic                   press;

  // Resets to the released level so reset never looks like a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_n};
    end
  end

  assign press = ~sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
    end else if (press == level_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_MAX) begin
      cnt_reg   <= '0;
      level_reg <= ~level_reg;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign deb_level = level_reg;

endmodule

// File: rtl/ddls_input_stage.sv
// Pushbutton + slide-switch front end producing one Valid/Ready transaction per press.
// Optional auto-repeat while the button is held: define INPUT_STAGE_AUTO_REPEAT_EN.
module ddls_input_stage
  import ddls_input_pkg::*;
#(
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_n,
  input  logic [DATA_W-1:0] sw_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("ddls_input_stage: SYNC_STAGES/DEBOUNCE_CYCLES must be >= 2, REPEAT_CYCLES >= 1");
  end

  in_state_t                          state_reg, state_next;
  logic [DATA_W-1:0]                  data_reg, data_next;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] sw_sync_reg;
  logic [DATA_W-1:0]                  sw_sync;
  logic                               deb_level;
  logic                               deb_prev_reg;
  logic                               deb_rise;
  logic                               rpt_due;
  logic                               launch;

  debounce_filter #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn_n),
    .deb_level (deb_level)
  );

  // Switches only need synchronising; they are sampled once per launch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_sync_reg <= '0;
    end else begin
      sw_sync_reg <= {sw_sync_reg[SYNC_STAGES-2:0], sw_in};
    end
  end

  assign sw_sync  = sw_sync_reg[SYNC_STAGES-1];
  assign deb_rise = deb_level & ~deb_prev_reg;

`ifdef INPUT_STAGE_AUTO_REPEAT_EN
  localparam int unsigned      RPT_W   = cnt_width(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_cnt_reg;

  assign rpt_due = (state_reg == HOLD) && deb_level && (rpt_cnt_reg == RPT_MAX);

  // Runs only while held in HOLD; any launch or release restarts the period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt_reg <= '0;
    end else if ((state_reg == HOLD) && deb_level && !rpt_due) begin
      rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
    end else begin
      rpt_cnt_reg <= '0;
    end
  end
`else
  assign rpt_due = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    launch     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (deb_rise) begin
          launch     = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        // Never abandoned: only a completed handshake leaves SEND
        if (out_valid && out_ready) begin
          state_next = deb_level ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (!deb_level) begin
          state_next = IDLE;
        end else if (rpt_due) begin
          launch     = 1'b1;
          state_next = SEND;
        end
      end
      default: state_next = IDLE;
    endcase
    if (launch) begin
      data_next = sw_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      data_reg     <= '0;
      deb_prev_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      data_reg     <= data_next;
      deb_prev_reg <= deb_level;
    end
  end

  assign out_valid = (state_reg == SEND);
  assign out_data  = data_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_ddls_input_stage.sv
// Scoreboard bench for ddls_input_stage with short debounce/repeat timings.
// Auto-repeat expectations follow INPUT_STAGE_AUTO_REPEAT_EN.
module tb_ddls_input_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_n = 1'b1;
  logic [7:0] sw_in = 8'h00;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int xfers = 0;
  int valid_cycles = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ddls_input_stage #(
    .DATA_W          (8),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_CYCLES   (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn_n),
    .sw_in     (sw_in),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int limit, output int lat);
    lat = 0;
    for (int i = 1; i <= limit; i++) begin
      cyc(1);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check_eq({tag, "_valid_seen"}, 32'(out_valid), 1);
  endtask

  // Handshake monitor: every accepted word is popped and compared
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      valid_cycles++;
      if (out_ready) begin
        xfers++;
        $display("xfer %0d data=%02h", xfers, out_data);
        check_eq("sb_avail", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          check_eq("xfer_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int lat;
    int x0;
    int v0;
    int held;
    int n_exp;

    cyc(3);
    check_eq("rst_valid", 32'(out_valid), 0);
    check_eq("rst_data", 32'(out_data), 0);
    check_eq("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    cyc(3);

    // 1: clean press, consumer ready
    sw_in = 8'hA5;
    out_ready = 1'b1;
    exp_q.push_back(8'hA5);
    btn_n = 1'b0;
    wait_valid("t1", 20, lat);
    check_eq("t1_latency_in_range", 32'(lat >= 6 && lat <= 8), 1);
    cyc(1);
    check_eq("t1_valid_one_cycle", 32'(out_valid), 0);
    check_eq("t1_hold_busy", 32'(busy), 1);
    btn_n = 1'b1;
    cyc(12);
    check_eq("t1_idle_after_release", 32'(busy), 0);

    // 2: short glitches are filtered
    v0 = valid_cycles;
    for (int k = 1; k <= 3; k++) begin
      btn_n = 1'b0;
      cyc(k);
      btn_n = 1'b1;
      cyc(10);
      check_eq($sformatf("t2_busy_glitch%0d", k), 32'(busy), 0);
    end
    check_eq("t2_no_valid", valid_cycles - v0, 0);

    // 3: back-pressure, release and switch change during SEND
    out_ready = 1'b0;
    sw_in = 8'h3C;
    exp_q.push_back(8'h3C);
    btn_n = 1'b0;
    wait_valid("t3", 20, lat);
    held = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 4) btn_n = 1'b1;
      if (i == 8) sw_in = 8'hFF;
      cyc(1);
      if (out_valid && out_data == 8'h3C) held++;
    end
    check_eq("t3_held_cycles", held, 20);
    check_eq("t3_data_stable", 32'(out_data), 32'h3C);
    x0 = xfers;
    out_ready = 1'b1;
    cyc(1);
    check_eq("t3_valid_drop", 32'(out_valid), 0);
    check_eq("t3_idle", 32'(busy), 0);
    cyc(3);
    check_eq("t3_single_xfer", xfers - x0, 1);

    // 4: asynchronous reset while valid
    out_ready = 1'b0;
    sw_in = 8'h5A;
    btn_n = 1'b0;
    wait_valid("t4", 20, lat);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t4_rst_valid", 32'(out_valid), 0);
    check_eq("t4_rst_data", 32'(out_data), 0);
    check_eq("t4_rst_busy", 32'(busy), 0);
    btn_n = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(12);
    check_eq("t4_valid_stays_low", 32'(out_valid), 0);
    check_eq("t4_busy_stays_low", 32'(busy), 0);

    // 5: long hold with consumer ready
`ifdef INPUT_STAGE_AUTO_REPEAT_EN
    n_exp = 3;
`else
    n_exp = 1;
`endif
    out_ready = 1'b1;
    sw_in = 8'h11;
    for (int i = 0; i < n_exp; i++) exp_q.push_back(8'h11);
    x0 = xfers;
    btn_n = 1'b0;
    cyc(30);
    btn_n = 1'b1;
    cyc(15);
    check_eq("t5_launches", xfers - x0, n_exp);
    check_eq("t5_idle", 32'(busy), 0);

    // 6: two separate presses
    x0 = xfers;
    sw_in = 8'hC3;
    exp_q.push_back(8'hC3);
    btn_n = 1'b0;
    cyc(10);
    btn_n = 1'b1;
    cyc(12);
    sw_in = 8'h7E;
    exp_q.push_back(8'h7E);
    btn_n = 1'b0;
    cyc(10);
    btn_n = 1'b1;
    cyc(12);
    check_eq("t6_two_xfers", xfers - x0, 2);
    check_eq("t6_idle", 32'(busy), 0);

    check_eq("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
